// File: rtl/fir_tap_sequencer_pkg.sv
// Shared widths, state encoding and saturation helper for the FIR tap sequencer.
package fir_tap_sequencer_pkg;
  localparam int SAMPLE_W = 24;
  localparam int COEF_W   = 16;
  localparam int ACC_W    = 48;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 24'h7F_FFFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 24'h80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_CAPTURE
  } seq_state_t;

  // A value fits in SAMPLE_W bits iff every bit from the sample sign bit upward agrees.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [ACC_W-1:0] v);
    logic [ACC_W-SAMPLE_W:0] top;
    top = v[ACC_W-1:SAMPLE_W-1];
    if ((&top) || !(|top)) return v[SAMPLE_W-1:0];
    return v[ACC_W-1] ? SAT_MIN : SAT_MAX;
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer; a write also loads the read register with the new sample, each rd_adv steps one older.
// Read data is registered (1 cycle); no backpressure, the sequencer paces all accesses.
module fir_delay_line
  import fir_tap_sequencer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_adv,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // rd_ptr always names the slot whose contents sit in rd_dat; wrap is free since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_dat <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
      rd_ptr      <= wr_ptr;
      rd_dat      <= wr_dat;
      wr_ptr      <= wr_ptr + 1'b1;
    end else if (rd_adv) begin
      rd_ptr <= rd_ptr - 1'b1;
      rd_dat <= mem[rd_ptr - 1'b1];
    end
  end
endmodule

// File: rtl/fir_tap_sequencer.sv
// Streams NUM_TAPS (sample, coef) beats into the FIR tap, drains its MAC pipeline and captures the sum.
// Latency sample_stb -> result_valid is NUM_TAPS+MAC_LATENCY+2; samples arriving while busy are dropped and flag overrun.
module fir_tap_sequencer
  import fir_tap_sequencer_pkg::*;
#(
  parameter int NUM_TAPS    = 32,
  parameter int MAC_LATENCY = 7,
  parameter int OUT_SHIFT   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_stb,
  input  logic [SAMPLE_W-1:0]         sample_in,
  input  logic                        coef_wr,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]           coef_data,
  output logic                        tap_en,
  output logic                        tap_clr,
  output logic [SAMPLE_W-1:0]         tap_data,
  output logic [COEF_W-1:0]           tap_coef,
  input  logic [ACC_W-1:0]            acc_in,
  output logic                        busy,
  output logic                        result_valid,
  output logic [ACC_W-1:0]            result,
  output logic [SAMPLE_W-1:0]         result_sat,
  output logic                        overrun
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam int KW = AW + 1;
  localparam int FW = $clog2(MAC_LATENCY + 1);

  seq_state_t        state;
  logic [KW-1:0]     k;
  logic [FW-1:0]     fl_cnt;
  logic [COEF_W-1:0] coef_tbl [NUM_TAPS];
  logic [SAMPLE_W-1:0] rd_dat;
  logic [ACC_W-1:0]  acc_sh;

  assign busy   = (state != ST_IDLE);
  assign acc_sh = $signed(acc_in) >>> OUT_SHIFT;

  fir_delay_line #(
    .DEPTH (NUM_TAPS),
    .W     (SAMPLE_W)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (sample_stb && (state == ST_IDLE)),
    .wr_dat  (sample_in),
    .rd_adv  ((state == ST_CLEAR) || (state == ST_RUN)),
    .rd_dat  (rd_dat)
  );

  // Written in IDLE only, so a write alongside sample_stb is seen by the first beat of that sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) coef_tbl[i[AW-1:0]] <= '0;
    end else if (coef_wr && (state == ST_IDLE)) begin
      coef_tbl[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      k            <= '0;
      fl_cnt       <= '0;
      tap_en       <= 1'b0;
      tap_clr      <= 1'b0;
      tap_data     <= '0;
      tap_coef     <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      result_sat   <= '0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (sample_stb && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (sample_stb) begin
            state    <= ST_CLEAR;
            tap_en   <= 1'b1;
            tap_clr  <= 1'b1;
            tap_data <= '0;
            tap_coef <= '0;
            k        <= '0;
          end
        end
        // k counts beats already loaded; CLEAR loads beat 0 on its way into RUN.
        ST_CLEAR, ST_RUN: begin
          tap_clr <= 1'b0;
          if (k == KW'(NUM_TAPS)) begin
            state    <= ST_FLUSH;
            tap_data <= '0;
            tap_coef <= '0;
            fl_cnt   <= '0;
          end else begin
            state    <= ST_RUN;
            tap_data <= rd_dat;
            tap_coef <= coef_tbl[k[AW-1:0]];
            k        <= k + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fl_cnt == FW'(MAC_LATENCY - 1)) begin
            state        <= ST_CAPTURE;
            tap_en       <= 1'b0;
            result       <= acc_in;
            result_sat   <= sat_sample(acc_sh);
            result_valid <= 1'b1;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        ST_CAPTURE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: FIR_Tap behavioural model on the tap port plus a direct-form FIR reference.
module tb_fir_tap_sequencer;
  localparam int N  = 4;
  localparam int M  = 7;
  localparam int SH = 0;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n, sample_stb, coef_wr;
  logic [23:0]   sample_in;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_data;
  logic          tap_en, tap_clr;
  logic [23:0]   tap_data;
  logic [15:0]   tap_coef;
  logic [47:0]   acc_in;
  logic          busy, result_valid, overrun;
  logic [47:0]   result;
  logic [23:0]   result_sat;

  always #5 clk = ~clk;

  fir_tap_sequencer #(
    .NUM_TAPS    (N),
    .MAC_LATENCY (M),
    .OUT_SHIFT   (SH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_stb   (sample_stb),
    .sample_in    (sample_in),
    .coef_wr      (coef_wr),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .tap_en       (tap_en),
    .tap_clr      (tap_clr),
    .tap_data     (tap_data),
    .tap_coef     (tap_coef),
    .acc_in       (acc_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .result_sat   (result_sat),
    .overrun      (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIR_Tap stand-in: accumulate product[39:8]; a beat seen in cycle c shows on acc_in in cycle c+M.
  longint      acc_m;
  longint      pipe_m [M];
  bit          force_en = 1'b0;
  logic [47:0] force_val = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      acc_m = 0;
      for (int i = 0; i < M; i++) pipe_m[i] = 0;
      acc_in = '0;
    end else begin
      acc_in = force_en ? force_val : 48'(pipe_m[M-1]);
      for (int i = M - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
      if (tap_en)
        acc_m = tap_clr ? 0 : acc_m + ((longint'($signed(tap_data)) * longint'($signed(tap_coef))) >>> 8);
      pipe_m[0] = acc_m;
    end
  end

  // Reference: y[n] = sum_k (x[n-k]*c[k])[39:8], history newest first.
  int coef_m [N];
  int hist_m [N];
  bit ovr_m;

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < N; k++) s += (longint'(hist_m[k]) * longint'(coef_m[k])) >>> 8;
    return s;
  endfunction

  function automatic logic [23:0] model_sat(input longint v);
    longint s = v >>> SH;
    if (s > 8388607)  return 24'h7FFFFF;
    if (s < -8388608) return 24'h800000;
    return 24'(s);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      coef_m[k] = 0;
      hist_m[k] = 0;
    end
    ovr_m = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0; sample_stb = 1'b0; coef_wr = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic write_coef(input int a, input int d);
    logic signed [15:0] cd;
    cd = 16'(d);
    @(negedge clk);
    coef_wr = 1'b1; coef_addr = AW'(a); coef_data = cd;
    @(negedge clk);
    coef_wr = 1'b0;
    coef_m[a] = cd;
  endtask

  // One sample from strobe to two cycles past CAPTURE, checking every tap beat and status per cycle.
  task automatic run_sample(input string tag, input logic [23:0] x, input int inj_cyc,
                            input bit cw_busy, input bit cw_same, input int cw_a, input int cw_d);
    logic [47:0] exp_res;
    logic [23:0] exp_sat, ed;
    logic [15:0] ec;
    logic signed [15:0] cd;
    logic een, eclr, eb, erv;
    @(negedge clk);
    sample_stb = 1'b1; sample_in = x;
    if (cw_same) begin
      cd = 16'(cw_d);
      coef_wr = 1'b1; coef_addr = AW'(cw_a); coef_data = cd;
      coef_m[cw_a] = cd;
    end
    for (int k = N - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = $signed(x);
    exp_res = force_en ? force_val : 48'(model_y());
    exp_sat = model_sat(force_en ? longint'($signed(force_val)) : model_y());
    if (inj_cyc != 0) ovr_m = 1'b1;
    for (int c = 1; c <= N + M + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin sample_stb = 1'b0; coef_wr = 1'b0; end
      if (c == inj_cyc) begin sample_stb = 1'b1; sample_in = 24'($urandom); end
      if (c == inj_cyc + 1 && inj_cyc != 0) sample_stb = 1'b0;
      if (cw_busy && c == 3) begin coef_wr = 1'b1; coef_addr = AW'($urandom); coef_data = 16'($urandom); end
      if (cw_busy && c == 4) coef_wr = 1'b0;
      een  = (c <= N + M + 1);
      eclr = (c == 1);
      eb   = (c <= N + M + 2);
      erv  = (c == N + M + 2);
      ed   = '0;
      ec   = '0;
      if (c >= 2 && c <= N + 1) begin
        ed = 24'(hist_m[c-2]);
        ec = 16'(coef_m[c-2]);
      end
      check($sformatf("%s:c%0d en/clr/data/coef/busy/rv", tag, c),
            64'({tap_en, tap_clr, tap_data, tap_coef, busy, result_valid}),
            64'({een, eclr, ed, ec, eb, erv}));
      if (c == N + M + 2 || c == N + M + 4) begin
        check($sformatf("%s:c%0d result", tag, c), 64'(result), 64'(exp_res));
        check($sformatf("%s:c%0d result_sat", tag, c), 64'(result_sat), 64'(exp_sat));
      end
    end
    check({tag, ":overrun"}, 64'(overrun), 64'(ovr_m));
  endtask

  initial begin
    int imp_exp [5];
    int stp_exp [5];
    imp_exp = '{1, 2, 3, 4, 0};
    stp_exp = '{1, 2, 3, 4, 4};
    reset_n = 1'b0; sample_stb = 1'b0; sample_in = '0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    model_clear();

    do_reset(3);
    check("rst:tap_en", 64'(tap_en), 64'(0));
    check("rst:tap_clr", 64'(tap_clr), 64'(0));
    check("rst:tap_data", 64'(tap_data), 64'(0));
    check("rst:tap_coef", 64'(tap_coef), 64'(0));
    check("rst:busy", 64'(busy), 64'(0));
    check("rst:result_valid", 64'(result_valid), 64'(0));
    check("rst:result", 64'(result), 64'(0));
    check("rst:result_sat", 64'(result_sat), 64'(0));
    check("rst:overrun", 64'(overrun), 64'(0));

    run_sample("zero", 24'h000000, 0, 1'b0, 1'b0, 0, 0);

    for (int k = 0; k < N; k++) write_coef(k, k + 1);
    for (int i = 0; i < 5; i++) begin
      run_sample($sformatf("imp%0d", i), (i == 0) ? 24'h000100 : 24'h000000, 0, 1'b0, 1'b0, 0, 0);
      check($sformatf("imp%0d:value", i), 64'(result), 64'(48'(imp_exp[i])));
    end

    for (int k = 0; k < N; k++) write_coef(k, -1);
    for (int i = 0; i < 5; i++) begin
      run_sample($sformatf("step%0d", i), 24'hFFFF00, 0, 1'b0, 1'b0, 0, 0);
      check($sformatf("step%0d:value", i), 64'(result), 64'(48'(stp_exp[i])));
    end

    run_sample("ovr", 24'h000200, 3, 1'b1, 1'b0, 0, 0);
    run_sample("after_ovr", 24'h000300, 0, 1'b0, 1'b0, 0, 0);
    run_sample("cwsame", 24'h000100, 0, 1'b0, 1'b1, 0, 7);

    // Reset during FLUSH: no result, overrun and tables cleared.
    @(negedge clk);
    sample_stb = 1'b1; sample_in = 24'h000100;
    for (int c = 1; c <= N + M + 6; c++) begin
      @(negedge clk);
      if (c == 1) sample_stb = 1'b0;
      if (c == N + 3) reset_n = 1'b0;
      if (c == N + 5) reset_n = 1'b1;
      check($sformatf("midrst:c%0d result_valid", c), 64'(result_valid), 64'(0));
    end
    model_clear();
    check("midrst:busy", 64'(busy), 64'(0));
    check("midrst:overrun", 64'(overrun), 64'(0));
    check("midrst:result", 64'(result), 64'(0));

    for (int k = 0; k < N; k++) write_coef(k, k + 1);
    for (int i = 0; i < 4; i++) begin
      run_sample($sformatf("postrst%0d", i), (i == 0) ? 24'h000100 : 24'h000000, 0, 1'b0, 1'b0, 0, 0);
      check($sformatf("postrst%0d:value", i), 64'(result), 64'(48'(imp_exp[i])));
    end

    run_sample("capdrop", 24'h000100, N + M + 2, 1'b0, 1'b0, 0, 0);
    run_sample("after_capdrop", 24'h000000, 0, 1'b0, 1'b0, 0, 0);

    for (int it = 0; it < 24; it++) begin
      int nw, inj, cwb, cws, ca, cdv;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        write_coef(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 65535)) - 32768);
      inj = ($urandom_range(0, 3) == 0) ? 3 : 0;
      cwb = int'($urandom_range(0, 3) == 0);
      cws = int'($urandom_range(0, 3) == 0);
      ca  = int'($urandom_range(0, N - 1));
      cdv = int'($urandom_range(0, 65535)) - 32768;
      run_sample($sformatf("rnd%0d", it), 24'($urandom), inj, cwb != 0, cws != 0, ca, cdv);
    end

    force_en = 1'b1;
    force_val = 48'h0000_0100_0000;
    run_sample("satpos", 24'h000000, 0, 1'b0, 1'b0, 0, 0);
    check("satpos:value", 64'(result_sat), 64'(24'h7FFFFF));
    force_val = 48'hFFFF_FF00_0000;
    run_sample("satneg", 24'h000000, 0, 1'b0, 1'b0, 0, 0);
    check("satneg:value", 64'(result_sat), 64'(24'h800000));
    force_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
